load_extractor: RTL and testbench

LOAD_EXTRACTOR -- requirements
Module: load_extractor

---
 rtl/load_extractor_if.sv | 25 ++
 rtl/load_extractor.sv | 123 ++++++++++++
 tb/tb_load_extractor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/load_extractor_if.sv
// Request/response and memory-read signals of the load extractor.
// The slave modport is the extractor's view; master is the driver/memory side.
interface load_extractor_if;
    logic        I_req;
    logic [31:0] I_addr;
    logic [2:0]  I_loadsel;
    logic        O_busy;
    logic        O_mem_req;
    logic [31:0] O_mem_addr;
    logic        I_mem_ack;
    logic [31:0] I_mem_rdata;
    logic        O_valid;
    logic [31:0] O_data;
    logic        O_fault;

    modport slave (
        input  I_req, I_addr, I_loadsel, I_mem_ack, I_mem_rdata,
        output O_busy, O_mem_req, O_mem_addr, O_valid, O_data, O_fault
    );

    modport master (
        output I_req, I_addr, I_loadsel, I_mem_ack, I_mem_rdata,
        input  O_busy, O_mem_req, O_mem_addr, O_valid, O_data, O_fault
    );
endinterface

// File: rtl/load_extractor.sv
// Single-outstanding load unit: word read, byte/half extraction, sign/zero extension, timeout.
// Define LOAD_MISALIGN_CHECK_EN to fault misaligned LH/LHU/LW without issuing a read.
module load_extractor #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic             I_clk,
    input logic             I_rst_n,
    load_extractor_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMreq, StResp} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic        misaligned;

    function automatic logic [31:0] extract(input logic [1:0] off, input logic [2:0] sel,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sel)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef LOAD_MISALIGN_CHECK_EN
    always_comb begin
        case (bus.I_loadsel)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = bus.I_addr[0];
            default:        misaligned = |bus.I_addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (bus.I_req) begin
                    addr_d = bus.I_addr;
                    sel_d  = bus.I_loadsel;
                    cnt_d  = '0;
                    if (misaligned) begin
                        data_d  = '0;
                        fault_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StMreq;
                    end
                end
            end
            StMreq: begin
                // Ack in the final allowed cycle still counts as a normal completion.
                if (bus.I_mem_ack) begin
                    data_d  = extract(addr_q[1:0], sel_q, bus.I_mem_rdata);
                    fault_d = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    data_d  = '0;
                    fault_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.O_busy     = (state_q != StIdle);
    assign bus.O_mem_req  = (state_q == StMreq);
    assign bus.O_mem_addr = {addr_q[31:2], 2'b00};
    assign bus.O_valid    = (state_q == StResp);
    assign bus.O_data     = data_q;
    assign bus.O_fault    = fault_q;

endmodule

// File: tb/tb_load_extractor.sv
// Bench for load_extractor: directed corner cases plus random loads checked
// against an arithmetic model of little-endian extraction and extension.
module tb_load_extractor;

    localparam int unsigned TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_extractor_if bus ();

    load_extractor #(.TIMEOUT(TO)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] sel);
`ifdef LOAD_MISALIGN_CHECK_EN
        if (sel == 3'b000 || sel == 3'b100) return 1'b0;
        if (sel == 3'b001 || sel == 3'b101) return a[0];
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] sel,
                                             input logic [31:0] w);
        int unsigned bsh;
        int unsigned hsh;
        logic [31:0] b;
        logic [31:0] h;
        bsh = 8 * int'(a[1:0]);
        hsh = a[1] ? 16 : 0;
        b = (w >> bsh) & 32'h0000_00FF;
        h = (w >> hsh) & 32'h0000_FFFF;
        case (sel)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // delay = number of no-ack MREQ cycles before ack; negative means never ack.
    task automatic run_load(input logic [31:0] a, input logic [2:0] sel,
                            input logic [31:0] w, input int delay);
        int          n;
        int          exp_n;
        logic [31:0] exp_d;
        logic        exp_f;
        @(negedge clk);
        bus.I_req       = 1'b1;
        bus.I_addr      = a;
        bus.I_loadsel   = sel;
        bus.I_mem_rdata = $urandom;
        @(negedge clk);
        bus.I_req     = 1'b0;
        bus.I_addr    = $urandom;
        bus.I_loadsel = 3'($urandom);
        if (ref_misaligned(a, sel)) begin
            check("mis_memreq", {31'd0, bus.O_mem_req}, 32'd0);
            exp_d = '0;
            exp_f = 1'b1;
        end else begin
            n     = 0;
            exp_n = (delay >= 0 && delay < int'(TO)) ? delay + 1 : int'(TO);
            while (!bus.O_valid && n <= int'(TO) + 2) begin
                check("memreq", {31'd0, bus.O_mem_req}, 32'd1);
                check("memaddr", bus.O_mem_addr, {a[31:2], 2'b00});
                bus.I_mem_ack   = (n == delay);
                bus.I_mem_rdata = (n == delay) ? w : 32'($urandom);
                @(negedge clk);
                bus.I_mem_ack = 1'b0;
                n++;
            end
            check("latency", 32'(n), 32'(exp_n));
            exp_f = !(delay >= 0 && delay < int'(TO));
            exp_d = exp_f ? 32'd0 : ref_load(a, sel, w);
        end
        check("valid", {31'd0, bus.O_valid}, 32'd1);
        check("resp_memreq", {31'd0, bus.O_mem_req}, 32'd0);
        check("data", bus.O_data, exp_d);
        check("fault", {31'd0, bus.O_fault}, {31'd0, exp_f});
        // A stray ack in RESP must not disturb the held result.
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = $urandom;
        @(negedge clk);
        bus.I_mem_ack = 1'b0;
        check("valid_pulse", {31'd0, bus.O_valid}, 32'd0);
        check("idle_busy", {31'd0, bus.O_busy}, 32'd0);
        check("data_hold", bus.O_data, exp_d);
        check("fault_hold", {31'd0, bus.O_fault}, {31'd0, exp_f});
    endtask

    initial begin
        int bursts;
        int valids;
        int blen;
        logic prev_valid;

        bus.I_req       = 1'b0;
        bus.I_addr      = '0;
        bus.I_loadsel   = '0;
        bus.I_mem_ack   = 1'b0;
        bus.I_mem_rdata = '0;

        #1;
        check("rst_busy", {31'd0, bus.O_busy}, 32'd0);
        check("rst_memreq", {31'd0, bus.O_mem_req}, 32'd0);
        check("rst_memaddr", bus.O_mem_addr, 32'd0);
        check("rst_valid", {31'd0, bus.O_valid}, 32'd0);
        check("rst_data", bus.O_data, 32'd0);
        check("rst_fault", {31'd0, bus.O_fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed extraction cases.
        run_load(32'h0000_0103, 3'b000, 32'h80FF_1234, 0);
        run_load(32'h0000_0102, 3'b101, 32'h8001_7FFF, 0);
        run_load(32'h0000_0102, 3'b001, 32'h8001_7FFF, 1);
        run_load(32'h0000_0100, 3'b001, 32'h8001_7FFF, 2);
        run_load(32'h0000_0101, 3'b100, 32'hA5C3_9F11, 0);
        run_load(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 0);
        run_load(32'h0000_0101, 3'b010, 32'h1357_9BDF, 0);
        run_load(32'h0000_0103, 3'b001, 32'hF00D_1234, 0);
        run_load(32'h0000_0204, 3'b111, 32'hCAFE_F00D, 0);
        // Timeout, and ack in the final allowed cycle.
        run_load(32'h0000_0300, 3'b010, 32'h1111_2222, -1);
        run_load(32'h0000_0304, 3'b000, 32'h0000_0081, int'(TO) - 1);

        // Request held high: each ack lands on the 4th MREQ cycle.
        @(negedge clk);
        bus.I_req     = 1'b1;
        bus.I_addr    = 32'h0000_0200;
        bus.I_loadsel = 3'b010;
        bursts     = 0;
        valids     = 0;
        blen       = 0;
        prev_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (prev_valid) check("held_idle_gap", {31'd0, bus.O_busy}, 32'd0);
            if (bus.O_mem_req) begin
                blen++;
            end else if (blen != 0) begin
                check("held_burst_len", 32'(blen), 32'd4);
                bursts++;
                blen = 0;
            end
            bus.I_mem_ack = (blen == 4);
            if (bus.O_valid) valids++;
            prev_valid = bus.O_valid;
        end
        bus.I_req     = 1'b0;
        bus.I_mem_ack = 1'b0;
        check("held_bursts", 32'(bursts), 32'd5);
        check("held_valids", 32'(valids), 32'd5);

        // Asynchronous reset in the middle of MREQ.
        @(negedge clk);
        bus.I_req     = 1'b1;
        bus.I_addr    = 32'h0000_0345;
        bus.I_loadsel = 3'b010;
        @(negedge clk);
        bus.I_req = 1'b0;
        check("pre_rst_memreq", {31'd0, bus.O_mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.O_busy}, 32'd0);
        check("arst_memreq", {31'd0, bus.O_mem_req}, 32'd0);
        check("arst_memaddr", bus.O_mem_addr, 32'd0);
        check("arst_valid", {31'd0, bus.O_valid}, 32'd0);
        check("arst_data", bus.O_data, 32'd0);
        check("arst_fault", {31'd0, bus.O_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = 32'h1234_5678;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, bus.O_valid}, 32'd0);
            check("post_rst_busy", {31'd0, bus.O_busy}, 32'd0);
        end
        bus.I_mem_ack = 1'b0;

        // Random loads; delays of TO and above time out.
        repeat (40) begin
            logic [31:0] ra;
            logic [2:0]  rs;
            logic [31:0] rw;
            int          rd;
            ra = $urandom;
            rs = 3'($urandom);
            rw = $urandom;
            rd = int'($urandom_range(0, TO + 1));
            run_load(ra, rs, rw, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
